// File: rtl/alu_ctrl_fsm.sv
// Sequences one instruction at a time through decode, ALU execute and
// writeback/branch, and counts retired legal instructions.
//
// state  | meaning
// IDLE   | ready for a new instruction word
// DECODE | classify captured word; illegal words pulse illegal_instr here
// EXEC   | ALU enabled with decoded op; branch result sampled at exit
// WB     | register-file write strobe
// BRANCH | pc_src strobe when the sampled branch result was set
module alu_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             beq_and_in1,
  output logic [4:0]       alu_op_ctrl,
  output logic             alu_control,
  output logic             beq_inst,
  output logic             alu_src,
  output logic             reg_write,
  output logic             pc_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       dec_legal;
  logic [4:0] dec_op;
  logic       dec_src;
  logic       dec_beq;

  // Only opcode and funct steer the controller; the operand fields belong to the datapath.
  logic unused_instr_fields;
  assign unused_instr_fields = ^instr[25:6];

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = 5'd0;
    dec_src   = 1'b0;
    dec_beq   = 1'b0;
    unique case (opcode_q)
      6'h00: begin
        unique case (funct_q)
          6'h25:   dec_op = 5'd0;
          6'h00:   dec_op = 5'd1;
          6'h26:   dec_op = 5'd2;
          6'h24:   dec_op = 5'd3;
          6'h22:   dec_op = 5'd4;
          6'h20:   dec_op = 5'd5;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h04: begin
        dec_op  = 5'd4;
        dec_beq = 1'b1;
      end
      6'h08: begin
        dec_op  = 5'd5;
        dec_src = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    funct_d       = funct_q;
    taken_d       = taken_q;
    cnt_d         = cnt_q;
    instr_ready   = 1'b0;
    alu_control   = 1'b0;
    alu_op_ctrl   = 5'd0;
    alu_src       = 1'b0;
    beq_inst      = 1'b0;
    reg_write     = 1'b0;
    pc_src        = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          opcode_d = instr[31:26];
          funct_d  = instr[5:0];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_instr = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_EXEC: begin
        alu_control = 1'b1;
        alu_op_ctrl = dec_op;
        alu_src     = dec_src;
        beq_inst    = dec_beq;
        if (dec_beq) begin
          taken_d = beq_and_in1;
          state_d = S_BRANCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = S_IDLE;
      end
      S_BRANCH: begin
        pc_src  = taken_q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
      taken_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      taken_q  <= taken_d;
      cnt_q    <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized bench for alu_ctrl_fsm: each instruction's cycle-by-cycle output
// profile is predicted from the decode rules and checked at the falling edge.
module tb_alu_ctrl_fsm;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic             beq_and_in1;
  logic [4:0]       alu_op_ctrl;
  logic             alu_control;
  logic             beq_inst;
  logic             alu_src;
  logic             reg_write;
  logic             pc_src;
  logic             illegal_instr;
  logic [CNT_W-1:0] retired_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  alu_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .beq_and_in1   (beq_and_in1),
    .alu_op_ctrl   (alu_op_ctrl),
    .alu_control   (alu_control),
    .beq_inst      (beq_inst),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .pc_src        (pc_src),
    .illegal_instr (illegal_instr),
    .retired_cnt   (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the instruction-set table.
  function automatic void model_decode(input logic [31:0] w, output bit legal,
                                       output int op, output bit src, output bit beq);
    logic [5:0] opc;
    logic [5:0] fn;
    opc = w[31:26];
    fn  = w[5:0];
    legal = 1; op = 0; src = 0; beq = 0;
    if (opc == 6'h00) begin
      if      (fn == 6'h25) op = 0;
      else if (fn == 6'h00) op = 1;
      else if (fn == 6'h26) op = 2;
      else if (fn == 6'h24) op = 3;
      else if (fn == 6'h22) op = 4;
      else if (fn == 6'h20) op = 5;
      else legal = 0;
    end else if (opc == 6'h04) begin
      op = 4; beq = 1;
    end else if (opc == 6'h08) begin
      op = 5; src = 1;
    end else begin
      legal = 0;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [6] = '{6'h25, 6'h00, 6'h26, 6'h24, 6'h22, 6'h20};
    logic [31:0] r;
    logic [31:0] w;
    int k;
    bit lg; int op; bit s; bit b;
    r = $urandom;
    k = $urandom_range(0, 8);
    if (k < 6)       w = {6'h00, r[25:6], fns[k]};
    else if (k == 6) w = {6'h04, r[25:0]};
    else if (k == 7) w = {6'h08, r[25:0]};
    else begin
      w = r;
      model_decode(w, lg, op, s, b);
      while (lg) begin
        r = $urandom;
        w = r;
        model_decode(w, lg, op, s, b);
      end
    end
    return w;
  endfunction

  task automatic busy_drive(input bit hold, input logic [31:0] nxt);
    logic [31:0] r;
    r = $urandom;
    if (hold) begin
      instr_valid = 1'b1;
      instr       = nxt;
    end else begin
      instr_valid = r[0];
      instr       = $urandom;
    end
    beq_and_in1 = r[1];
  endtask

  // Entered just after a falling edge with the DUT idle; returns one falling
  // edge after the DUT is expected back in IDLE.
  task automatic run_instr(input logic [31:0] w, input bit taken,
                           input bit hold, input logic [31:0] nxt);
    bit legal; int op; bit src; bit beq;
    model_decode(w, legal, op, src, beq);
    instr_valid = 1'b1;
    instr       = w;
    #1;
    chk("idle_ready", instr_ready, 1);
    chk("idle_cnt", retired_cnt, exp_cnt);
    chk("idle_alu_en", alu_control, 0);
    @(negedge clk);
    busy_drive(hold, nxt);
    #1;
    chk("dec_ready", instr_ready, 0);
    chk("dec_illegal", illegal_instr, !legal);
    chk("dec_alu_en", alu_control, 0);
    chk("dec_strobes", {reg_write, pc_src}, 0);
    if (legal) begin
      @(negedge clk);
      busy_drive(hold, nxt);
      beq_and_in1 = taken;
      #1;
      chk("exec_alu_en", alu_control, 1);
      chk("exec_op", alu_op_ctrl, op);
      chk("exec_src", alu_src, src);
      chk("exec_beq", beq_inst, beq);
      chk("exec_ready", instr_ready, 0);
      chk("exec_illegal", illegal_instr, 0);
      @(negedge clk);
      busy_drive(hold, nxt);
      #1;
      chk("fin_reg_write", reg_write, !beq);
      chk("fin_pc_src", pc_src, beq && taken);
      chk("fin_alu_zero", {alu_control, alu_op_ctrl, alu_src, beq_inst}, 0);
      chk("fin_ready", instr_ready, 0);
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end
    @(negedge clk);
    if (hold) begin
      instr_valid = 1'b1;
      instr       = nxt;
    end else begin
      instr_valid = 1'b0;
    end
    #1;
    chk("back_ready", instr_ready, 1);
    chk("back_cnt", retired_cnt, exp_cnt);
    chk("back_strobes", {reg_write, pc_src, illegal_instr, alu_control}, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    beq_and_in1 = 1'b0;
    #2;
    chk("rst_ready", instr_ready, 1);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_outs", {alu_control, alu_op_ctrl, alu_src, beq_inst,
                     reg_write, pc_src, illegal_instr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(32'h0000_0020, 1'b0, 1'b0, 32'h0);
    run_instr(32'h1000_0000, 1'b1, 1'b0, 32'h0);
    run_instr(32'h1000_0000, 1'b0, 1'b0, 32'h0);
    run_instr(32'h2000_0005, 1'b0, 1'b0, 32'h0);
    run_instr(32'hFC00_0000, 1'b1, 1'b0, 32'h0);

    // Word held valid across a busy period is taken on the next idle edge.
    run_instr(32'h0000_0026, 1'b0, 1'b1, 32'h0000_0025);
    run_instr(32'h0000_0025, 1'b0, 1'b0, 32'h0);

    // Reset while a SUB is in EXEC.
    instr_valid = 1'b1;
    instr       = 32'h0000_0022;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("sub_exec_op", alu_op_ctrl, 4);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {alu_control, alu_op_ctrl, alu_src, beq_inst,
                       reg_write, pc_src, illegal_instr}, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_cnt", retired_cnt, 0);
    exp_cnt = 0;
    @(negedge clk);
    #1;
    chk("abort_no_wb", reg_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'h0000_0020, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 70; i++) begin
      logic [31:0] r;
      r = $urandom;
      run_instr(rand_instr(), r[0], 1'b0, 32'h0);
    end

    // Exactly 16 legal instructions bring the 4-bit counter back around.
    begin
      int start;
      start = exp_cnt;
      for (int i = 0; i < 16; i++) run_instr(32'h0000_0000, 1'b0, 1'b0, 32'h0);
      chk("wrap_cnt", retired_cnt, start);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid, input, 1, an instruction word is offered.
REQ-005 SHALL have port instr, input, 32, instruction word: opcode instr[31:26], funct instr[5:0].
REQ-006 SHALL have port instr_ready, output, 1, block accepts an instruction this cycle.
REQ-007 SHALL have port beq_and_in1, input, 1, branch-equal result returned by the ALU.
REQ-008 SHALL have port alu_op_ctrl, output, 5, ALU operation select.
REQ-009 SHALL have port alu_control, output, 1, ALU enable.
REQ-010 SHALL have port beq_inst, output, 1, current operation is a branch compare.
REQ-011 SHALL have port alu_src, output, 1, 1 selects the immediate as second ALU operand.
REQ-012 SHALL have port reg_write, output, 1, one-cycle register-file write strobe.
REQ-013 SHALL have port pc_src, output, 1, one-cycle branch-taken strobe.
REQ-014 SHALL have port illegal_instr, output, 1, one-cycle undecodable-instruction strobe.
REQ-015 SHALL have port retired_cnt, output, CNT_W, count of completed legal instructions.

Function
REQ-016 SHALL implement states IDLE, DECODE, EXEC, WB, BRANCH; all outputs decoded from state and captured registers only (Moore).
REQ-017 SHALL assert instr_ready exactly when in IDLE.
REQ-018 SHALL capture instr on the edge where instr_valid && instr_ready, then go to DECODE; instr is ignored in all other cycles.
REQ-019 SHALL decode in DECODE: opcode 0 with funct 0x25 OR->0, 0x00 SLL->1, 0x26 XNOR->2, 0x24 NAND->3, 0x22 SUB->4, 0x20 ADD->5; opcode 0x04 BEQ->4 with branch flag; opcode 0x08 ADDI->5 with alu_src=1.
REQ-020 SHALL treat any other opcode/funct as illegal: pulse illegal_instr for the DECODE cycle, return to IDLE, no ALU enable, no counter increment.
REQ-021 SHALL go DECODE->EXEC for legal instructions; in EXEC drive alu_control=1, alu_op_ctrl=decoded code, alu_src per decode, beq_inst=1 only for BEQ.
REQ-022 SHALL drive alu_op_ctrl=0, alu_src=0, beq_inst=0 whenever alu_control=0.
REQ-023 SHALL, at the end of EXEC, register beq_and_in1 as the taken flag for BEQ and go to BRANCH; non-branch goes to WB.
REQ-024 SHALL assert reg_write for the single WB cycle, then return to IDLE.
REQ-025 SHALL assert pc_src in the single BRANCH cycle only if the taken flag is 1, then return to IDLE.
REQ-026 SHALL increment retired_cnt by 1 on leaving WB or BRANCH; wraps from all-ones to 0.
REQ-027 SHALL give legal-instruction latency of 4 cycles from accept edge to instr_ready high again; illegal 2 cycles.
REQ-028 SHALL ignore instr_valid toggling while busy; a word held valid across the busy period is accepted on the next IDLE edge.

Reset
REQ-029 SHALL, while rst_n low, force state IDLE, retired_cnt=0, taken flag=0, captured instruction=0, all strobes and ALU outputs 0, instr_ready=1.
REQ-030 SHALL abort any in-flight instruction on reset assertion mid-operation with no reg_write/pc_src pulse and no count.
REQ-031 SHALL accept a new instruction on the first rising edge after rst_n deasserts if instr_valid is high.

Verification
REQ-032 SHALL cover ADD: instr=32'h0000_0020 accepted -> EXEC alu_control=1, alu_op_ctrl=5, alu_src=0; reg_write one cycle later; retired_cnt 0->1.
REQ-033 SHALL cover BEQ taken/not-taken: instr=32'h1000_0000, beq_and_in1=1 in EXEC -> beq_inst=1, alu_op_ctrl=4, pc_src=1 next cycle; repeat with 0 -> pc_src=0, no reg_write.
REQ-034 SHALL cover ADDI: instr=32'h2000_0005 -> alu_op_ctrl=5, alu_src=1, reg_write pulse.
REQ-035 SHALL cover illegal: instr=32'hFC00_0000 -> illegal_instr one cycle, alu_control never 1, retired_cnt unchanged, instr_ready high 2 cycles after accept.
REQ-036 SHALL cover reset in EXEC of a SUB (32'h0000_0022) -> all outputs 0, instr_ready=1, retired_cnt=0, no reg_write.
REQ-037 SHALL cover counter wrap with CNT_W=4: 16 legal instructions -> retired_cnt returns to 0.
